wb_ram_slave: RTL and testbench
===============================

# wb_ram_slave

Wishbone responder: a single-port word-addressed SRAM behind the shared `wb_bus_t` slave modport, serving load and store cycles issued by the LSU's Wishbone master port. Decodes a configurable address window, inserts a fixed number of wait states, and applies byte-lane writes from `wb_sel`. Accesses outside the window terminate with `wb_err`. Sits on the data-side bus as the core's data memory and scratchpad.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h1000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_STATES`, 0: cycles inserted between request sample and ack; 0..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-high.
- `wb_bus` `wb_bus_t.slave`:
  - Inputs used: `wb_adr`[31:0], `wb_dat_ms`[31:0], `wb_sel`[3:0], `wb_we`, `wb_cyc`, `wb_stb`.
  - Inputs ignored: `wb_tga`, `wb_tgc`, `wb_tgd_ms`, `wb_lock`.
  - Outputs driven: `wb_dat_sm`[31:0], `wb_ack`, `wb_err`.
  - Outputs tied to 0: `wb_rty`, `wb_gnt`, `wb_tgd_sm`.

## Operation
- Request: `wb_cyc & wb_stb` high in IDLE at a rising edge.
- Hit: `wb_adr - BASE_ADDR < DEPTH_WORDS*4` (unsigned, 32-bit wrap). Word index = `(wb_adr - BASE_ADDR) >> 2`; `wb_adr[1:0]` ignored.
- On request, latch address, `wb_we`, `wb_sel` and `wb_dat_ms`; later master changes do not affect the transfer.
- FSM states: IDLE, WAIT, RESP, ERR.
  - IDLE → ERR: request that misses.
  - IDLE → RESP: hit with `WAIT_STATES`=0.
  - IDLE → WAIT: hit with `WAIT_STATES`>0; load wait counter with `WAIT_STATES`-1.
  - WAIT: counter decrements each cycle. At 0 → RESP. If `wb_cyc` is low → IDLE (abort).
  - RESP and ERR → IDLE unconditionally after one cycle.
- Write: performed on the edge entering RESP.
  - Byte lane k = latched data[8k+7:8k] when latched `sel[k]`; other lanes unchanged.
  - `sel`=0 acks with no change.
- Read: word is registered on the edge entering RESP and appears on `wb_dat_sm` during RESP.
- `wb_ack` = (state==RESP); `wb_err` = (state==ERR); never both high.
- `wb_dat_sm` = 0 outside a read RESP cycle.
- Read and write in the same transfer are impossible; `wb_we` selects.
- Memory contents are not reset; initial contents undefined. No memory-init port.

## Timing
- Reset values: state IDLE, counter 0; `wb_ack`, `wb_err`, `wb_dat_sm`, `wb_rty`, `wb_gnt`, `wb_tgd_sm` all 0.
- Request sampled at edge N. `wb_ack` is high for exactly one cycle, from edge N+1+`WAIT_STATES`.
- `wb_err` is high for exactly one cycle, from edge N+1, regardless of `WAIT_STATES`.
- Master drops `wb_stb` after sampling ack/err (classic cycle). If `stb` is still high in IDLE after RESP/ERR, it is a new request (back-to-back), giving 1 idle-free turnaround cycle.
- Throughput: one transfer per `2+WAIT_STATES` cycles.
- Abort: `wb_cyc` low during WAIT gives no write and no ack. `wb_stb` low during WAIT with `cyc` high is ignored; the transfer completes.
- `rst_i` asserted mid-transfer: outputs 0 immediately (async), no write committed, FSM returns to IDLE. Release is synchronous to `clk`.
- Address wrap: `wb_adr` < `BASE_ADDR` wraps to a large difference and returns err; top-of-window word `BASE_ADDR+DEPTH_WORDS*4-4` hits.

## Test plan
- Defaults. Write 0xDEADBEEF to 0x1000_0010 with `sel`=1111, then read it back → ack 1 cycle after each request, read data 0xDEADBEEF.
- Byte lanes. Write 0x11223344 `sel`=1111, then 0xAABBCCDD `sel`=0101 at 0x1000_0020; read → 0x11BB33DD.
- `WAIT_STATES`=3: read request at edge N → ack only in cycle N+4; `wb_dat_sm`=0 in all other cycles.
- Out of range: read 0x0FFF_FFFC and 0x1000_1000 (DEPTH 1024) → err at N+1, no ack. Read 0x1000_0FFC → ack.
- Abort and reset. With `WAIT_STATES`=3, write 0x5555_5555 and drop `cyc` in WAIT → no ack, old data retained. Repeat with `rst_i` pulsed mid-WAIT → outputs 0 at once, memory unchanged.
- Back-to-back: hold `stb` through RESP with a new address → second transfer acks at N+3 (`WAIT_STATES`=0), both accesses correct.

Source files
------------

// File: rtl/wb_ram_slave.sv
// wb_ram_slave
// Wishbone responder wrapping a single-port, word-addressed SRAM used as the
// core's data memory / scratchpad on the data-side bus.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_i      : asynchronous, active-high reset
//   wb_adr     : byte address from the master (bits [1:0] ignored)
//   wb_dat_ms  : write data, master to slave
//   wb_sel     : byte-lane enables for writes
//   wb_we      : 1 = store, 0 = load
//   wb_cyc     : bus cycle in progress (dropping it in WAIT aborts the transfer)
//   wb_stb     : strobe; cyc & stb in IDLE is a request
//   wb_dat_sm  : read data, valid only during a read acknowledge, else 0
//   wb_ack     : one-cycle acknowledge for an in-window access
//   wb_err     : one-cycle error for an out-of-window access
//   wb_rty, wb_gnt, wb_tgd_sm : never used by this slave, held at 0
//
// The bus tag and lock inputs (tga, tgc, tgd_ms, lock) carry nothing this
// memory acts on, so they are not brought into the module at all.

module wb_ram_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_ms,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_dat_sm,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_rty,
  output logic        wb_gnt,
  output logic [3:0]  wb_tgd_sm
);

  localparam int          AW           = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] idx_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          request;
  logic [31:0]   offset;
  logic          hit;
  logic [AW-1:0] req_idx;

  // Window decode by subtraction: an address below BASE_ADDR wraps to a huge
  // offset and so falls outside the window without a second comparison.
  assign request = wb_cyc & wb_stb;
  assign offset  = wb_adr - BASE_ADDR;
  assign hit     = (offset < WINDOW_BYTES);
  assign req_idx = offset[AW+1:2];

  // With zero wait states the memory access happens on the same edge that
  // samples the request, so the live bus is used; otherwise the copy latched
  // in IDLE is used so later master changes cannot disturb the transfer.
  logic          from_idle;
  logic [AW-1:0] eff_idx;
  logic          eff_we;
  logic [3:0]    eff_sel;
  logic [31:0]   eff_dat;
  logic          commit;

  assign from_idle = (state == S_IDLE);
  assign eff_idx   = from_idle ? req_idx   : idx_q;
  assign eff_we    = from_idle ? wb_we     : we_q;
  assign eff_sel   = from_idle ? wb_sel    : sel_q;
  assign eff_dat   = from_idle ? wb_dat_ms : dat_q;

  // The access is committed only on the edge that enters RESP, and never
  // while reset is held.
  assign commit = (state_nxt == S_RESP) && !rst_i;

  // State register, wait counter and request capture.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && request) begin
        idx_q    <= req_idx;
        we_q     <= wb_we;
        sel_q    <= wb_sel;
        dat_q    <= wb_dat_ms;
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Next-state logic. A dropped wb_stb in WAIT is deliberately ignored; only
  // wb_cyc going low abandons the transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (request) begin
          if (!hit)
            state_nxt = S_ERR;
          else if (WAIT_STATES == 0)
            state_nxt = S_RESP;
          else
            state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc)
          state_nxt = S_IDLE;
        else if (wait_cnt == 4'd0)
          state_nxt = S_RESP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory array and read register. Contents are intentionally not reset;
  // rdata_q is only visible through the gated output, so it needs no reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (eff_we) begin
        for (int k = 0; k < 4; k++) begin
          if (eff_sel[k])
            mem[eff_idx][8*k +: 8] <= eff_dat[8*k +: 8];
        end
      end else begin
        rdata_q <= mem[eff_idx];
      end
    end
  end

  // Outputs decode purely from state, so an asynchronous reset clears them
  // immediately.
  always_comb begin
    wb_ack    = (state == S_RESP);
    wb_err    = (state == S_ERR);
    wb_dat_sm = 32'd0;
    if (state == S_RESP && !we_q)
      wb_dat_sm = rdata_q;
  end

  assign wb_rty    = 1'b0;
  assign wb_gnt    = 1'b0;
  assign wb_tgd_sm = 4'd0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave
// Directed bench for wb_ram_slave. Two instances share the clock, reset and
// bus inputs: dut0 has no wait states, dut3 has three. use3 steers cyc/stb to
// exactly one of them and selects whose outputs the tasks observe.

module tb_wb_ram_slave;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        use3;

  logic [31:0] dat0, dat3;
  logic        ack0, ack3, err0, err3, rty0, rty3, gnt0, gnt3;
  logic [3:0]  tgd0, tgd3;

  logic [31:0] dat_m;
  logic        ack_m;
  logic        err_m;

  int n_checks = 0;
  int n_fail   = 0;

  assign ack_m = use3 ? ack3 : ack0;
  assign err_m = use3 ? err3 : err0;
  assign dat_m = use3 ? dat3 : dat0;

  wb_ram_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_i(rst), .wb_adr(adr), .wb_dat_ms(dat_ms), .wb_sel(sel), .wb_we(we),
    .wb_cyc(cyc & ~use3), .wb_stb(stb & ~use3), .wb_dat_sm(dat0), .wb_ack(ack0),
    .wb_err(err0), .wb_rty(rty0), .wb_gnt(gnt0), .wb_tgd_sm(tgd0)
  );

  wb_ram_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_i(rst), .wb_adr(adr), .wb_dat_ms(dat_ms), .wb_sel(sel), .wb_we(we),
    .wb_cyc(cyc & use3), .wb_stb(stb & use3), .wb_dat_sm(dat3), .wb_ack(ack3),
    .wb_err(err3), .wb_rty(rty3), .wb_gnt(gnt3), .wb_tgd_sm(tgd3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one classic cycle starting at a negedge. Cycle k is observed at the
  // k-th negedge after the sampling edge; cyc/stb drop once ack or err is seen.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int ack_cyc, output int err_cyc,
                          output int n_resp, output int stray, output logic [31:0] rdat);
    ack_cyc = -1;
    err_cyc = -1;
    n_resp  = 0;
    stray   = 0;
    rdat    = 32'hx;
    adr     = a;
    dat_ms  = d;
    sel     = s;
    we      = w;
    cyc     = 1'b1;
    stb     = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dat_m !== 32'd0 && !(ack_m === 1'b1 && !w)) stray++;
      if (ack_m === 1'b1 || err_m === 1'b1) begin
        n_resp++;
        if (ack_m === 1'b1 && ack_cyc < 0) begin
          ack_cyc = k;
          rdat    = dat_m;
        end
        if (err_m === 1'b1 && err_cyc < 0) err_cyc = k;
        cyc = 1'b0;
        stb = 1'b0;
      end
    end
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({ack0, err0, ack3, err3} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ack_err: got %b, expected 0000", {ack0, err0, ack3, err3});
    end
    n_checks++;
    if (dat0 !== 32'd0 || dat3 !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_dat: got %h/%h, expected 0/0", dat0, dat3);
    end
    n_checks++;
    if ({rty0, gnt0, tgd0, rty3, gnt3, tgd3} !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_tied: got %h, expected 0", {rty0, gnt0, tgd0, rty3, gnt3, tgd3});
    end
  endtask

  task automatic test_defaults;
    int ac, ec, nr, st;
    logic [31:0] rd;
    use3 = 1'b0;
    bus_xfer(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ac !== 1 || ec !== -1 || nr !== 1 || st !== 0) begin
      n_fail++;
      $display("[TB] FAIL defaults_write: got ack@%0d err@%0d n=%0d stray=%0d, expected ack@1 err@-1 n=1 stray=0", ac, ec, nr, st);
    end
    bus_xfer(1'b0, 32'h1000_0010, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ac !== 1 || nr !== 1 || st !== 0) begin
      n_fail++;
      $display("[TB] FAIL defaults_read_timing: got ack@%0d n=%0d stray=%0d, expected ack@1 n=1 stray=0", ac, nr, st);
    end
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL defaults_read_data: got %h, expected deadbeef", rd);
    end
    bus_xfer(1'b0, 32'h1000_0013, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF || ac !== 1) begin
      n_fail++;
      $display("[TB] FAIL unaligned_read: got %h ack@%0d, expected deadbeef ack@1", rd, ac);
    end
  endtask

  task automatic test_byte_lanes;
    int ac, ec, nr, st;
    logic [31:0] rd;
    use3 = 1'b0;
    bus_xfer(1'b1, 32'h1000_0020, 32'h1122_3344, 4'hF, ac, ec, nr, st, rd);
    bus_xfer(1'b1, 32'h1000_0020, 32'hAABB_CCDD, 4'b0101, ac, ec, nr, st, rd);
    bus_xfer(1'b0, 32'h1000_0020, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (rd !== 32'h11BB_33DD) begin
      n_fail++;
      $display("[TB] FAIL byte_lanes: got %h, expected 11bb33dd", rd);
    end
    bus_xfer(1'b1, 32'h1000_0020, 32'hFFFF_FFFF, 4'b0000, ac, ec, nr, st, rd);
    n_checks++;
    if (ac !== 1 || nr !== 1) begin
      n_fail++;
      $display("[TB] FAIL sel0_ack: got ack@%0d n=%0d, expected ack@1 n=1", ac, nr);
    end
    bus_xfer(1'b0, 32'h1000_0020, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (rd !== 32'h11BB_33DD) begin
      n_fail++;
      $display("[TB] FAIL sel0_nochange: got %h, expected 11bb33dd", rd);
    end
  endtask

  task automatic test_wait_states;
    int ac, ec, nr, st;
    logic [31:0] rd;
    use3 = 1'b1;
    bus_xfer(1'b1, 32'h1000_0040, 32'hCAFE_F00D, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ac !== 4 || nr !== 1 || st !== 0) begin
      n_fail++;
      $display("[TB] FAIL ws3_write: got ack@%0d n=%0d stray=%0d, expected ack@4 n=1 stray=0", ac, nr, st);
    end
    bus_xfer(1'b0, 32'h1000_0040, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ac !== 4 || nr !== 1 || st !== 0 || rd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("[TB] FAIL ws3_read: got ack@%0d n=%0d stray=%0d data=%h, expected ack@4 n=1 stray=0 data=cafef00d", ac, nr, st, rd);
    end
  endtask

  task automatic test_out_of_range;
    int ac, ec, nr, st;
    logic [31:0] rd;
    use3 = 1'b0;
    bus_xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ec !== 1 || ac !== -1 || nr !== 1) begin
      n_fail++;
      $display("[TB] FAIL below_window: got err@%0d ack@%0d n=%0d, expected err@1 ack@-1 n=1", ec, ac, nr);
    end
    bus_xfer(1'b0, 32'h1000_1000, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ec !== 1 || ac !== -1 || nr !== 1) begin
      n_fail++;
      $display("[TB] FAIL above_window: got err@%0d ack@%0d n=%0d, expected err@1 ack@-1 n=1", ec, ac, nr);
    end
    use3 = 1'b1;
    bus_xfer(1'b0, 32'h1000_1000, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ec !== 1 || ac !== -1 || nr !== 1) begin
      n_fail++;
      $display("[TB] FAIL ws3_err: got err@%0d ack@%0d n=%0d, expected err@1 ack@-1 n=1", ec, ac, nr);
    end
    use3 = 1'b0;
    bus_xfer(1'b1, 32'h1000_0FFC, 32'h0BAD_F00D, 4'hF, ac, ec, nr, st, rd);
    bus_xfer(1'b0, 32'h1000_0FFC, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (ac !== 1 || ec !== -1 || rd !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("[TB] FAIL top_word: got ack@%0d err@%0d data=%h, expected ack@1 err@-1 data=0badf00d", ac, ec, rd);
    end
  endtask

  task automatic test_abort;
    int ac, ec, nr, st;
    int acks;
    logic [31:0] rd;
    use3 = 1'b1;
    bus_xfer(1'b1, 32'h1000_0080, 32'h1234_5678, 4'hF, ac, ec, nr, st, rd);
    adr    = 32'h1000_0080;
    dat_ms = 32'h5555_5555;
    sel    = 4'hF;
    we     = 1'b1;
    cyc    = 1'b1;
    stb    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc  = 1'b0;
    stb  = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_m === 1'b1 || err_m === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_ack: got %0d responses, expected 0", acks);
    end
    bus_xfer(1'b0, 32'h1000_0080, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (rd !== 32'h1234_5678 || ac !== 4) begin
      n_fail++;
      $display("[TB] FAIL abort_retained: got %h ack@%0d, expected 12345678 ack@4", rd, ac);
    end
  endtask

  task automatic test_reset_abort;
    int ac, ec, nr, st;
    logic [31:0] rd;
    use3   = 1'b1;
    adr    = 32'h1000_0080;
    dat_ms = 32'h5555_5555;
    sel    = 4'hF;
    we     = 1'b1;
    cyc    = 1'b1;
    stb    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 1'b0;
    stb = 1'b0;
    #1;
    n_checks++;
    if (ack_m !== 1'b0 || err_m !== 1'b0 || dat_m !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_wait_outputs: got ack=%b err=%b dat=%h, expected 0 0 0", ack_m, err_m, dat_m);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_xfer(1'b0, 32'h1000_0080, 32'h0, 4'hF, ac, ec, nr, st, rd);
    n_checks++;
    if (rd !== 32'h1234_5678 || ac !== 4) begin
      n_fail++;
      $display("[TB] FAIL rst_no_write: got %h ack@%0d, expected 12345678 ack@4", rd, ac);
    end
    // Reset asserted while a read acknowledge is on the bus must clear it at once.
    adr = 32'h1000_0080;
    we  = 1'b0;
    cyc = 1'b1;
    stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (ack_m !== 1'b1 || dat_m !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL rst_pre_ack: got ack=%b dat=%h, expected 1 12345678", ack_m, dat_m);
    end
    rst = 1'b1;
    cyc = 1'b0;
    stb = 1'b0;
    #1;
    n_checks++;
    if (ack_m !== 1'b0 || dat_m !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_async_clear: got ack=%b dat=%h, expected 0 0", ack_m, dat_m);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    use3   = 1'b0;
    adr    = 32'h1000_0100;
    dat_ms = 32'hA5A5_0F0F;
    sel    = 4'hF;
    we     = 1'b1;
    cyc    = 1'b1;
    stb    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ack_m !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_first_ack: got %b, expected 1", ack_m);
    end
    we     = 1'b0;
    dat_ms = 32'h0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ack_m !== 1'b0 || err_m !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_turnaround: got ack=%b err=%b, expected 0 0", ack_m, err_m);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ack_m !== 1'b1 || dat_m !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got ack=%b dat=%h, expected 1 a5a50f0f", ack_m, dat_m);
    end
    cyc = 1'b0;
    stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    adr    = 32'd0;
    dat_ms = 32'd0;
    sel    = 4'd0;
    we     = 1'b0;
    cyc    = 1'b0;
    stb    = 1'b0;
    use3   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_defaults;
    test_byte_lanes;
    test_wait_states;
    test_out_of_range;
    test_abort;
    test_reset_abort;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
